cp0_except_ctrl: RTL
====================

CP0_EXCEPT_CTRL -- requirements
Module: cp0_except_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: i_ena  in  1  MEM stage advancing this cycle; no exception, eret or mtc0 takes effect while 0.
REQ-004 SHALL have port: i_MEM_current_pc  in  32  PC of instruction in MEM.
REQ-005 SHALL have port: i_MEM_current_instr  in  32  instruction word; bits [15:11] select CP0 register.
REQ-006 SHALL have port: i_MEM_CP0_we  in  1  mtc0 write request.
REQ-007 SHALL have port: i_MEM_CP0_wdata  in  32  mtc0 data.
REQ-008 SHALL have port: i_MEM_CP0_except_cause  in  5  ExcCode; 5'h1F = none.
REQ-009 SHALL have port: i_MEM_current_is_in_delay_slot  in  1  instruction is in branch delay slot.
REQ-010 SHALL have port: i_MEM_is_eret  in  1  eret in MEM.
REQ-011 SHALL have port: i_MEM_bad_vaddr  in  32  faulting address for AdEL/AdES.
REQ-012 SHALL have port: i_hw_int  in  6  level-sensitive hardware interrupt lines.
REQ-013 SHALL have port: o_CP0_rdata  out  32  combinational read of register selected by instr[15:11]; 0 for unimplemented.
REQ-014 SHALL have port: o_except_flush  out  1  combinational; redirect fetch and flush IF..MEM this cycle.
REQ-015 SHALL have port: o_except_target  out  32  redirect PC, valid when o_except_flush=1.

Function
REQ-016 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); others read 0, writes ignored.
REQ-017 Status SHALL implement IE=bit0, EXL=bit1, IM=bits[15:8]; other bits read 0.
REQ-018 Cause SHALL implement BD=bit31, TI=bit30, IP=bits[15:8], ExcCode=bits[6:2]; other bits read 0.
REQ-019 SHALL sample IP[7:2] each cycle: IP[6:2]=i_hw_int[4:0], IP[7]=i_hw_int[5] | TI; IP[1:0] writable by mtc0 only.
REQ-020 Count SHALL increment by 1 every second cycle (internal toggle bit), wrapping 32'hFFFFFFFF -> 0.
REQ-021 TI SHALL set on the edge after the cycle where Count==Compare; mtc0 to Compare SHALL clear TI; clear wins over simultaneous set.
REQ-022 mtc0 to Count SHALL load Count and clear the toggle bit; it takes priority over increment.
REQ-023 Interrupt pending SHALL = IE & ~EXL & |(IP & IM).
REQ-024 Exception taken SHALL = i_ena & (cause != 5'h1F | interrupt pending); interrupt uses ExcCode 0 and has priority over the instruction's cause.
REQ-025 On exception taken with EXL=0: EPC <= delay_slot ? pc-4 : pc; BD <= delay_slot; ExcCode <= cause; EXL <= 1.
REQ-026 On exception taken with EXL=1: ExcCode updated; EPC and BD unchanged; EXL stays 1.
REQ-027 On exception with cause 4 or 5: BadVAddr <= i_MEM_bad_vaddr.
REQ-028 Exception: o_except_flush=1, o_except_target=32'hBFC00380, same cycle.
REQ-029 eret (i_ena, no exception): o_except_flush=1, o_except_target=current EPC, EXL <= 0 on the edge.
REQ-030 Priority SHALL be exception > eret > mtc0; an exception or eret SHALL suppress the same-cycle mtc0.
REQ-031 mtc0 result SHALL be visible on o_CP0_rdata from the next cycle; no internal write-read bypass.
REQ-032 o_except_flush SHALL be 0 whenever i_ena=0.

Reset
REQ-033 resetn low SHALL asynchronously clear all CP0 registers, TI and toggle bit to 0; o_except_flush=0, o_except_target=0xBFC00380.
REQ-034 Reset asserted mid-operation SHALL abort any pending update; first post-reset edge sees only reset values.

Verification
REQ-035 Reset: assert resetn=0 after Count=0x55 -> all reads 0, flush 0, same cycle.
REQ-036 Overflow: Status=0x1, cause=12, pc=0x100, ds=0, i_ena=1 -> flush=1, target=0xBFC00380; next cycle EPC=0x100, Cause[6:2]=12, Status=0x3.
REQ-037 Delay slot: cause=4, pc=0x204, ds=1, bad_vaddr=0x13 -> EPC=0x200, BD=1, BadVAddr=0x13.
REQ-038 eret: EPC=0x100, EXL=1 -> flush=1, target=0x100; next cycle Status[1]=0.
REQ-039 Timer: Compare=4, Status=0x8001, Count from 0 -> TI=1 one edge after Count==4; next i_ena cycle takes interrupt, ExcCode=0.
REQ-040 Collision: mtc0 Status=0x0 with cause=8 same cycle -> exception taken, Status=0x3 (write suppressed), EPC=pc.

Source files
------------

// File: rtl/cp0_except_ctrl.sv
// MIPS-style CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC) that
// resolves exceptions, interrupts, eret and mtc0 for the instruction in MEM.
module cp0_except_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_ena,
   input  logic [31:0] i_MEM_current_pc,
   input  logic [31:0] i_MEM_current_instr,
   input  logic        i_MEM_CP0_we,
   input  logic [31:0] i_MEM_CP0_wdata,
   input  logic [4:0]  i_MEM_CP0_except_cause,
   input  logic        i_MEM_current_is_in_delay_slot,
   input  logic        i_MEM_is_eret,
   input  logic [31:0] i_MEM_bad_vaddr,
   input  logic [5:0]  i_hw_int,
   output logic [31:0] o_CP0_rdata,
   output logic        o_except_flush,
   output logic [31:0] o_except_target
);

   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   localparam logic [4:0]  CAUSE_NONE   = 5'h1F;
   localparam logic [4:0]  CAUSE_ADEL   = 5'd4;
   localparam logic [4:0]  CAUSE_ADES   = 5'd5;
   localparam logic [4:0]  REG_BADVADDR = 5'd8;
   localparam logic [4:0]  REG_COUNT    = 5'd9;
   localparam logic [4:0]  REG_COMPARE  = 5'd11;
   localparam logic [4:0]  REG_STATUS   = 5'd12;
   localparam logic [4:0]  REG_CAUSE    = 5'd13;
   localparam logic [4:0]  REG_EPC      = 5'd14;

   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q,    count_d;
   logic [31:0] compare_q,  compare_d;
   logic [31:0] epc_q,      epc_d;
   logic        toggle_q,   toggle_d;
   logic        ti_q,       ti_d;
   logic        bd_q,       bd_d;
   logic        ie_q,       ie_d;
   logic        exl_q,      exl_d;
   logic [7:0]  im_q,       im_d;
   logic [5:0]  ip_hw_q,    ip_hw_d;
   logic [1:0]  ip_sw_q,    ip_sw_d;
   logic [4:0]  exccode_q,  exccode_d;

   logic [4:0]  reg_sel;
   logic [31:0] status_word;
   logic [31:0] cause_word;
   logic        int_pending;
   logic        exc_taken;
   logic [4:0]  exc_code;
   logic        eret_taken;
   logic        mtc0_taken;
   logic        unused_instr_bits;

   assign reg_sel           = i_MEM_current_instr[15:11];
   assign unused_instr_bits = ^{i_MEM_current_instr[31:16], i_MEM_current_instr[10:0]};

   assign status_word = {16'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_word  = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

   // An interrupt overrides whatever the instruction itself raised.
   assign int_pending = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
   assign exc_taken   = i_ena & ((i_MEM_CP0_except_cause != CAUSE_NONE) | int_pending);
   assign exc_code    = int_pending ? 5'd0 : i_MEM_CP0_except_cause;
   assign eret_taken  = i_ena & i_MEM_is_eret & ~exc_taken;
   assign mtc0_taken  = i_ena & i_MEM_CP0_we & ~exc_taken & ~eret_taken;

   // Redirect is suppressed while reset is held so the pipeline sees a quiet port.
   assign o_except_flush  = resetn & (exc_taken | eret_taken);
   assign o_except_target = (resetn & eret_taken) ? epc_q : EXC_VECTOR;

   always_comb begin
      o_CP0_rdata = 32'd0;
      case (reg_sel)
         REG_BADVADDR: o_CP0_rdata = badvaddr_q;
         REG_COUNT:    o_CP0_rdata = count_q;
         REG_COMPARE:  o_CP0_rdata = compare_q;
         REG_STATUS:   o_CP0_rdata = status_word;
         REG_CAUSE:    o_CP0_rdata = cause_word;
         REG_EPC:      o_CP0_rdata = epc_q;
         default:      o_CP0_rdata = 32'd0;
      endcase
   end

   always_comb begin
      badvaddr_d = badvaddr_q;
      count_d    = count_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      toggle_d   = ~toggle_q;
      ti_d       = ti_q;
      bd_d       = bd_q;
      ie_d       = ie_q;
      exl_d      = exl_q;
      im_d       = im_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      ip_hw_d    = {i_hw_int[5] | ti_q, i_hw_int[4:0]};

      if (toggle_q) begin
         count_d = count_q + 32'd1;
      end
      if (count_q == compare_q) begin
         ti_d = 1'b1;
      end

      if (exc_taken) begin
         if (!exl_q) begin
            epc_d = i_MEM_current_is_in_delay_slot ? (i_MEM_current_pc - 32'd4)
                                                   : i_MEM_current_pc;
            bd_d  = i_MEM_current_is_in_delay_slot;
         end
         exccode_d = exc_code;
         exl_d     = 1'b1;
         if (exc_code == CAUSE_ADEL || exc_code == CAUSE_ADES) begin
            badvaddr_d = i_MEM_bad_vaddr;
         end
      end else if (eret_taken) begin
         exl_d = 1'b0;
      end else if (mtc0_taken) begin
         case (reg_sel)
            REG_COUNT: begin
               count_d  = i_MEM_CP0_wdata;
               toggle_d = 1'b0;
            end
            REG_COMPARE: begin
               compare_d = i_MEM_CP0_wdata;
               ti_d      = 1'b0;
            end
            REG_STATUS: begin
               im_d  = i_MEM_CP0_wdata[15:8];
               exl_d = i_MEM_CP0_wdata[1];
               ie_d  = i_MEM_CP0_wdata[0];
            end
            REG_CAUSE: ip_sw_d = i_MEM_CP0_wdata[9:8];
            REG_EPC:   epc_d   = i_MEM_CP0_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         badvaddr_q <= 32'd0;
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         epc_q      <= 32'd0;
         toggle_q   <= 1'b0;
         ti_q       <= 1'b0;
         bd_q       <= 1'b0;
         ie_q       <= 1'b0;
         exl_q      <= 1'b0;
         im_q       <= 8'd0;
         ip_hw_q    <= 6'd0;
         ip_sw_q    <= 2'd0;
         exccode_q  <= 5'd0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         toggle_q   <= toggle_d;
         ti_q       <= ti_d;
         bd_q       <= bd_d;
         ie_q       <= ie_d;
         exl_q      <= exl_d;
         im_q       <= im_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
      end
   end

endmodule
